// File: rtl/burst_bus_scheduler_if.sv
// Request/write-data/bus bundle shared between the two requesters, the scheduler and the burst bus.
// The slave view belongs to the scheduler; the master view drives requests and the bus-side ready.
interface burst_bus_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int SIZE_W = 8
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [SIZE_W-1:0] req_size0;
    logic [SIZE_W-1:0] req_size1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        wvalid;
    logic [1:0]        wready;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic              bus_start;
    logic [SIZE_W-1:0] bus_size;
    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_data;
    logic              bus_valid;
    logic              bus_ready;

    modport master (
        output req, req_addr0, req_addr1, req_size0, req_size1,
        output wdata0, wdata1, wvalid, bus_ready,
        input  wready, gnt, done, bus_start, bus_size, bus_address, bus_data, bus_valid
    );

    modport slave (
        input  req, req_addr0, req_addr1, req_size0, req_size1,
        input  wdata0, wdata1, wvalid, bus_ready,
        output wready, gnt, done, bus_start, bus_size, bus_address, bus_data, bus_valid
    );
endinterface

// File: rtl/burst_bus_scheduler.sv
// Round-robin scheduler sharing one burst bus between two requesters:
// start strobe, SIZE beats under backpressure, then a fixed idle gap.
module burst_bus_scheduler #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int SIZE_W     = 8,
    parameter int GAP_CYCLES = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    burst_bus_scheduler_if.slave  bif
);

    localparam int  GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam bit  HAS_GAP  = (GAP_CYCLES != 0);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BURST = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [SIZE_W-1:0] r_remain;
    logic [GAP_W-1:0]  r_gap;
    logic [1:0]        r_done;

    logic              w_winner;
    logic              w_wvalid_g;
    logic [DATA_W-1:0] w_wdata_g;
    logic              w_beat;
    logic              w_finish;
    logic              w_capture;

    // On a tie the requester that did not own the previous burst wins.
    always_comb begin
        w_winner = 1'b0;
        case (bif.req)
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = ~r_last;
            default: w_winner = 1'b0;
        endcase
    end

    assign w_wvalid_g = r_owner ? bif.wvalid[1] : bif.wvalid[0];
    assign w_wdata_g  = r_owner ? bif.wdata1 : bif.wdata0;
    assign w_capture  = (r_state == S_IDLE) && (bif.req != 2'b00);
    assign w_beat     = (r_state == S_BURST) && w_wvalid_g && bif.bus_ready;
    assign w_finish   = ((r_state == S_START) && (r_remain == '0)) ||
                        (w_beat && (r_remain == SIZE_W'(1)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bif.req != 2'b00) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (r_remain == '0) begin
                    w_next = HAS_GAP ? S_GAP : S_IDLE;
                end else begin
                    w_next = S_BURST;
                end
            end
            S_BURST: begin
                if (w_beat && (r_remain == SIZE_W'(1))) begin
                    w_next = HAS_GAP ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Control registers; the done pulse lands in the cycle after completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_remain <= '0;
            r_gap    <= '0;
            r_done   <= 2'b00;
        end else begin
            r_done <= 2'b00;
            if (w_capture) begin
                r_owner  <= w_winner;
                r_remain <= w_winner ? bif.req_size1 : bif.req_size0;
            end
            if (w_beat) begin
                r_remain <= r_remain - SIZE_W'(1);
            end
            if (w_finish) begin
                r_done <= r_owner ? 2'b10 : 2'b01;
                r_last <= r_owner;
                r_gap  <= GAP_LOAD;
            end
            if ((r_state == S_GAP) && (r_gap != '0)) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    // Beat address wraps naturally at the address width.
    always_ff @(posedge clock) begin
        if (w_capture) begin
            r_addr <= w_winner ? bif.req_addr1 : bif.req_addr0;
        end else if (w_beat) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    always_comb begin
        bif.gnt         = 2'b00;
        bif.wready      = 2'b00;
        bif.bus_start   = 1'b0;
        bif.bus_size    = '0;
        bif.bus_address = '0;
        bif.bus_data    = '0;
        bif.bus_valid   = 1'b0;
        case (r_state)
            S_START: begin
                bif.gnt[r_owner] = 1'b1;
                bif.bus_start    = 1'b1;
                bif.bus_size     = r_remain;
                bif.bus_address  = r_addr;
            end
            S_BURST: begin
                bif.gnt[r_owner]    = 1'b1;
                bif.wready[r_owner] = bif.bus_ready;
                bif.bus_address     = r_addr;
                bif.bus_data        = w_wdata_g;
                bif.bus_valid       = w_wvalid_g;
            end
            default: begin
            end
        endcase
    end

    assign bif.done = r_done;

endmodule

// File: tb/tb_burst_bus_scheduler.sv
// Bench for burst_bus_scheduler: two instances (gap 10 and gap 0) share one stimulus stream and
// are compared every cycle against a transaction-level reference model of the scheduling rules.
module tb_burst_bus_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  t_req;
  logic [15:0] t_addr0, t_addr1;
  logic [7:0]  t_size0, t_size1;
  logic [31:0] t_wd0, t_wd1;
  logic [1:0]  t_wvalid;
  logic        t_ready;

  burst_bus_scheduler_if if_g ();
  burst_bus_scheduler_if if_z ();

  assign if_g.req = t_req;       assign if_z.req = t_req;
  assign if_g.req_addr0 = t_addr0; assign if_z.req_addr0 = t_addr0;
  assign if_g.req_addr1 = t_addr1; assign if_z.req_addr1 = t_addr1;
  assign if_g.req_size0 = t_size0; assign if_z.req_size0 = t_size0;
  assign if_g.req_size1 = t_size1; assign if_z.req_size1 = t_size1;
  assign if_g.wdata0 = t_wd0;    assign if_z.wdata0 = t_wd0;
  assign if_g.wdata1 = t_wd1;    assign if_z.wdata1 = t_wd1;
  assign if_g.wvalid = t_wvalid; assign if_z.wvalid = t_wvalid;
  assign if_g.bus_ready = t_ready; assign if_z.bus_ready = t_ready;

  burst_bus_scheduler #(.GAP_CYCLES(10)) u_dut_g (.clock(clk), .reset(rst), .bif(if_g.slave));
  burst_bus_scheduler #(.GAP_CYCLES(0))  u_dut_z (.clock(clk), .reset(rst), .bif(if_z.slave));

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: phase 0 idle, 1 start, 2 beats, 3 gap.
  int         gap_len[2] = '{10, 0};
  int         m_phase[2], m_owner[2], m_last[2], m_base[2], m_size[2], m_cnt[2], m_gap[2];
  logic [1:0] m_done[2];

  int beats[2], dones[2];
  int starts_q[$];
  int addr_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic [1:0] gnt, input logic [1:0] done,
                            input logic [1:0] wready, input logic bs, input logic [7:0] bsz,
                            input logic [15:0] ba, input logic [31:0] bd, input logic bv);
    logic [1:0]  e_gnt, e_wr;
    logic        e_bs, e_bv;
    logic [7:0]  e_bsz;
    logic [15:0] e_ba;
    logic [31:0] e_bd;
    string       p;
    p = (k == 0) ? "g10" : "g0";
    e_gnt = 2'b00; e_wr = 2'b00; e_bs = 1'b0; e_bv = 1'b0;
    e_bsz = 8'h0;  e_ba = 16'h0; e_bd = 32'h0;
    if (m_phase[k] == 1) begin
      e_gnt = 2'(1 << m_owner[k]);
      e_bs  = 1'b1;
      e_bsz = 8'(m_size[k]);
      e_ba  = 16'(m_base[k]);
    end else if (m_phase[k] == 2) begin
      e_gnt = 2'(1 << m_owner[k]);
      e_ba  = 16'((m_base[k] + m_cnt[k]) % 65536);
      e_bv  = t_wvalid[m_owner[k]];
      e_bd  = (m_owner[k] == 1) ? t_wd1 : t_wd0;
      e_wr  = t_ready ? e_gnt : 2'b00;
    end
    chk({p, ".gnt"},       64'(gnt),    64'(e_gnt));
    chk({p, ".done"},      64'(done),   64'(m_done[k]));
    chk({p, ".wready"},    64'(wready), 64'(e_wr));
    chk({p, ".bus_start"}, 64'(bs),     64'(e_bs));
    chk({p, ".bus_size"},  64'(bsz),    64'(e_bsz));
    chk({p, ".bus_addr"},  64'(ba),     64'(e_ba));
    chk({p, ".bus_valid"}, 64'(bv),     64'(e_bv));
    chk({p, ".bus_data"},  64'(bd),     64'(e_bd));
    if (bv && t_ready) begin
      beats[k]++;
      if (k == 0) addr_q.push_back(int'(ba));
    end
    if (done != 2'b00) dones[k]++;
    if (k == 0 && bs) starts_q.push_back(gnt[1] ? 1 : 0);
  endtask

  task automatic model_finish(input int k);
    m_done[k] = 2'(1 << m_owner[k]);
    m_last[k] = m_owner[k];
    if (gap_len[k] == 0) begin
      m_phase[k] = 0;
    end else begin
      m_phase[k] = 3;
      m_gap[k]   = gap_len[k];
    end
  endtask

  task automatic model_update(input int k);
    if (rst) begin
      m_phase[k] = 0; m_last[k] = 1; m_done[k] = 2'b00; m_owner[k] = 0;
      return;
    end
    m_done[k] = 2'b00;
    case (m_phase[k])
      0: if (t_req != 2'b00) begin
        if (t_req == 2'b11) m_owner[k] = 1 - m_last[k];
        else                m_owner[k] = (t_req == 2'b10) ? 1 : 0;
        m_base[k]  = (m_owner[k] == 1) ? int'(t_addr1) : int'(t_addr0);
        m_size[k]  = (m_owner[k] == 1) ? int'(t_size1) : int'(t_size0);
        m_cnt[k]   = 0;
        m_phase[k] = 1;
      end
      1: if (m_size[k] == 0) model_finish(k);
         else m_phase[k] = 2;
      2: if (t_wvalid[m_owner[k]] && t_ready) begin
        m_cnt[k]++;
        if (m_cnt[k] == m_size[k]) model_finish(k);
      end
      default: begin
        m_gap[k]--;
        if (m_gap[k] == 0) m_phase[k] = 0;
      end
    endcase
  endtask

  task automatic step();
    #1;
    check_inst(0, if_g.gnt, if_g.done, if_g.wready, if_g.bus_start, if_g.bus_size,
               if_g.bus_address, if_g.bus_data, if_g.bus_valid);
    check_inst(1, if_z.gnt, if_z.done, if_z.wready, if_z.bus_start, if_z.bus_size,
               if_z.bus_address, if_z.bus_data, if_z.bus_valid);
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
  endtask

  task automatic clear_obs();
    beats[0] = 0; beats[1] = 0; dones[0] = 0; dones[1] = 0;
    starts_q.delete();
    addr_q.delete();
  endtask

  initial begin
    rst = 1'b1; t_req = 2'b00; t_addr0 = 16'h0; t_addr1 = 16'h0; t_size0 = 8'd0; t_size1 = 8'd0;
    t_wd0 = 32'h0; t_wd1 = 32'h0; t_wvalid = 2'b11; t_ready = 1'b1;
    repeat (2) @(posedge clk);
    model_update(0); model_update(1);
    @(negedge clk);
    step();
    rst = 1'b0;

    // Single burst of 4 from requester 0
    clear_obs();
    t_addr0 = 16'h0010; t_size0 = 8'd4; t_wd0 = 32'hA5A5_0001; t_req = 2'b01;
    step();
    t_req = 2'b00;
    repeat (17) step();
    chk("t1.beats_g10", 64'(beats[0]), 64'd4);
    chk("t1.done_g10",  64'(dones[0]), 64'd1);
    chk("t1.beats_g0",  64'(beats[1]), 64'd4);
    chk("t1.addr_first", 64'(addr_q[0]), 64'h10);
    chk("t1.addr_last",  64'(addr_q[3]), 64'h13);

    // Contention straight after reset: grants alternate 0,1,0,1
    rst = 1'b1; t_req = 2'b11;
    step();
    rst = 1'b0; clear_obs();
    t_size0 = 8'd2; t_size1 = 8'd2; t_addr1 = 16'h0200; t_wd1 = 32'h5A5A_0002;
    repeat (60) step();
    t_req = 2'b00;
    chk("t2.nstarts", 64'(starts_q.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < starts_q.size(); i++)
      chk("t2.order", 64'(starts_q[i]), 64'(i % 2));
    repeat (16) step();

    // Backpressure: size 3, bus_ready low for two cycles mid-burst
    clear_obs();
    t_addr0 = 16'h0100; t_size0 = 8'd3; t_req = 2'b01;
    step();
    t_req = 2'b00;
    step();
    t_ready = 1'b1; step();
    t_ready = 1'b0; step(); step();
    t_ready = 1'b1;
    repeat (14) step();
    chk("t3.beats", 64'(beats[0]), 64'd3);
    chk("t3.done",  64'(dones[0]), 64'd1);

    // Address wrap
    clear_obs();
    t_addr0 = 16'hFFFE; t_size0 = 8'd4; t_req = 2'b01;
    step();
    t_req = 2'b00;
    repeat (18) step();
    chk("t4.nbeats", 64'(addr_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      chk("t4.addr", 64'(addr_q[i]), 64'((16'hFFFE + i) % 65536));

    // Size-0 burst from requester 1
    clear_obs();
    t_size1 = 8'd0; t_req = 2'b10;
    step();
    t_req = 2'b00;
    repeat (3) step();
    chk("t5.beats_g0", 64'(beats[1]), 64'd0);
    chk("t5.done_g0",  64'(dones[1]), 64'd1);
    repeat (10) step();

    // Reset during beat 2 of 5, then a tie goes to requester 0
    t_addr0 = 16'h0300; t_size0 = 8'd5; t_req = 2'b01;
    step();
    t_req = 2'b00;
    step();
    step();
    clear_obs();
    rst = 1'b1;
    step();
    rst = 1'b0; t_req = 2'b11;
    step();
    chk("t6.no_done", 64'(dones[0]), 64'd0);
    step();
    t_req = 2'b00;
    chk("t6.first_owner", 64'(starts_q.size() > 0 ? starts_q[0] : 9), 64'd0);
    repeat (20) step();

    // Randomised traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 249) == 0);
      t_req    = 2'($urandom_range(0, 3));
      t_addr0  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFA, 16'hFFFF)) : 16'($urandom);
      t_addr1  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFA, 16'hFFFF)) : 16'($urandom);
      t_size0  = 8'($urandom_range(0, 6));
      t_size1  = 8'($urandom_range(0, 6));
      t_wd0    = $urandom;
      t_wd1    = $urandom;
      t_wvalid = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      t_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
